// File: rtl/seg7_capture.sv
// Recovers the hex digit shown on an active-low 7-segment bus. A pattern must be
// seen STABLE_CYCLES times in a row before it is committed, reported and counted.
module seg7_capture #(
   parameter int STABLE_CYCLES = 4,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       leds,
   input  logic             clear_count,
   output logic [3:0]       val,
   output logic             blank,
   output logic             invalid,
   output logic             update,
   output logic [CNT_W-1:0] change_count
);

   localparam int SW = $clog2(STABLE_CYCLES + 1);
   localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);

   logic [6:0]    samp;
   logic [6:0]    cand;
   logic [6:0]    committed;
   logic [SW-1:0] stab;
   logic          commit;

   // Returns {val, blank, invalid} for a raw segment pattern.
   function automatic logic [5:0] decode(input logic [6:0] p);
      logic [5:0] r;
      r = {4'h0, 1'b0, 1'b1};
      case (p)
         7'h40: r = {4'h0, 2'b00};
         7'h79: r = {4'h1, 2'b00};
         7'h24: r = {4'h2, 2'b00};
         7'h30: r = {4'h3, 2'b00};
         7'h19: r = {4'h4, 2'b00};
         7'h12: r = {4'h5, 2'b00};
         7'h02: r = {4'h6, 2'b00};
         7'h78: r = {4'h7, 2'b00};
         7'h00: r = {4'h8, 2'b00};
         7'h10: r = {4'h9, 2'b00};
         7'h08: r = {4'hA, 2'b00};
         7'h03: r = {4'hB, 2'b00};
         7'h46: r = {4'hC, 2'b00};
         7'h21: r = {4'hD, 2'b00};
         7'h06: r = {4'hE, 2'b00};
         7'h0E: r = {4'hF, 2'b00};
         7'h7F: r = {4'h0, 2'b10};
         default: r = {4'h0, 2'b01};
      endcase
      return r;
   endfunction

   // update is a single-cycle valid strobe with no ready: the accompanying
   // val/blank/invalid/change_count are valid in the same cycle and hold afterwards.
   assign commit = (stab == STAB_MAX) && (cand != committed);

   always_ff @(posedge clk) begin
      if (reset) begin
         samp         <= 7'h7F;
         cand         <= 7'h7F;
         stab         <= '0;
         committed    <= 7'h7F;
         val          <= 4'h0;
         blank        <= 1'b1;
         invalid      <= 1'b0;
         update       <= 1'b0;
         change_count <= '0;
      end else begin
         samp <= leds;
         if (samp != cand) begin
            cand <= samp;
            stab <= SW'(1);
         end else if (stab != STAB_MAX) begin
            stab <= stab + 1'b1;
         end

         update <= commit;
         if (commit) begin
            committed              <= cand;
            {val, blank, invalid}  <= decode(cand);
         end

         // A clear that coincides with a commit leaves the count at one.
         if (clear_count)
            change_count <= CNT_W'(commit);
         else if (commit)
            change_count <= change_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_seg7_capture.sv
// Randomized bench for seg7_capture: a sample-window reference model predicts each
// commit into a queue, and a negedge monitor pops and compares on every update.
module tb_seg7_capture;

   localparam int SC = 4;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [6:0] leds = 7'h7F;
   logic       clear_count = 1'b0;

   logic [3:0] val, val2;
   logic       blank, invalid, update, blank2, invalid2, update2;
   logic [7:0] change_count;
   logic [1:0] change_count2;

   always #5 clk = ~clk;

   seg7_capture #(.STABLE_CYCLES(SC), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .leds(leds), .clear_count(clear_count),
      .val(val), .blank(blank), .invalid(invalid), .update(update),
      .change_count(change_count)
   );

   seg7_capture #(.STABLE_CYCLES(SC), .CNT_W(2)) dut_w2 (
      .clk(clk), .reset(reset), .leds(leds), .clear_count(clear_count),
      .val(val2), .blank(blank2), .invalid(invalid2), .update(update2),
      .change_count(change_count2)
   );

   logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   int checks = 0;
   int failures = 0;
   int cycle = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // ---------------- reference model ----------------
   // Entry: {stamp[31:0], val[3:0], blank, invalid, count8[7:0], count2[1:0]}
   logic [47:0] exp_q [$];
   logic [6:0]  hist [$];
   logic [6:0]  m_committed = 7'h7F;
   logic [3:0]  m_val = 4'h0;
   logic        m_blank = 1'b1;
   logic        m_invalid = 1'b0;
   int          m_count = 0;

   task automatic model_decode(input logic [6:0] p, output logic [3:0] v,
                               output logic b, output logic inv);
      v = 4'h0; b = 1'b0; inv = 1'b1;
      if (p == 7'h7F) begin
         b = 1'b1; inv = 1'b0;
      end else begin
         for (int i = 0; i < 16; i++)
            if (glyph[i] == p) begin
               v = 4'(i); inv = 1'b0;
            end
      end
   endtask

   always @(posedge clk) begin
      logic       commit;
      logic [6:0] p;
      int         n;
      cycle++;
      if (reset) begin
         hist.delete();
         hist.push_back(7'h7F);
         m_committed = 7'h7F;
         m_val = 4'h0; m_blank = 1'b1; m_invalid = 1'b0;
         m_count = 0;
      end else begin
         hist.push_back(leds);
         if (hist.size() > 16) void'(hist.pop_front());
         n = hist.size();
         commit = 1'b0;
         p = 7'h7F;
         // Commit needs SC identical samples ending two samples before this one.
         if (n >= SC + 2) begin
            p = hist[n-3];
            commit = 1'b1;
            for (int i = 1; i < SC; i++)
               if (hist[n-3-i] != p) commit = 1'b0;
            if (p == m_committed) commit = 1'b0;
         end
         if (clear_count) m_count = 0;
         if (commit) begin
            m_count++;
            m_committed = p;
            model_decode(p, m_val, m_blank, m_invalid);
            exp_q.push_back({32'(cycle), m_val, m_blank, m_invalid,
                             8'(m_count % 256), 2'(m_count % 4)});
         end
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      logic [47:0] e;
      if (cycle > 0) begin
         while (exp_q.size() > 0 && int'(exp_q[0][47:16]) < cycle) begin
            e = exp_q.pop_front();
            check("missed_update_at_cycle", 0, int'(e[47:16]));
         end
         if (update) begin
            if (exp_q.size() == 0) begin
               check("unexpected_update", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("upd_val", val, e[15:12]);
               check("upd_blank", blank, e[11]);
               check("upd_invalid", invalid, e[10]);
               check("upd_count8", change_count, e[9:2]);
               check("upd_count2", change_count2, e[1:0]);
            end
         end
         check("update_w2_matches", update2, update);
         check("state_val", val, m_val);
         check("state_blank", blank, m_blank);
         check("state_invalid", invalid, m_invalid);
         check("state_count8", change_count, m_count % 256);
         check("state_count2", change_count2, m_count % 4);
      end
   end

   // ---------------- drivers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic hold(input logic [6:0] p, input int n);
      leds = p;
      repeat (n) step();
   endtask

   task automatic latency(input logic [6:0] p, input string name);
      int lat;
      int ups;
      lat = 0; ups = 0;
      leds = p;
      for (int i = 1; i <= 12; i++) begin
         step();
         if (update) begin
            ups++;
            if (lat == 0) lat = i;
         end
      end
      check(name, lat, SC + 2);
      check({name, "_single"}, ups, 1);
   endtask

   initial begin
      step();
      step();
      check("reset_val", val, 0);
      check("reset_blank", blank, 1);
      check("reset_invalid", invalid, 0);
      check("reset_update", update, 0);
      check("reset_count", change_count, 0);

      // Test 1: first commit latency
      reset = 1'b0;
      latency(7'h40, "lat_40");
      check("t1_val", val, 0);
      check("t1_blank", blank, 0);
      check("t1_count", change_count, 1);

      // Test 2: full sweep
      do_reset();
      for (int i = 0; i < 16; i++) begin
         hold(glyph[i], 10);
         check("sweep_val", val, i);
         check("sweep_invalid", invalid, 0);
      end
      check("sweep_count", change_count, 16);

      // Test 3: short glitch back to committed pattern
      hold(7'h79, 10);
      hold(7'h24, 3);
      hold(7'h79, 10);
      check("glitch_val", val, 1);
      check("glitch_count", change_count, 17);

      // Test 4: invalid then blank
      do_reset();
      hold(7'h55, 10);
      check("inv_invalid", invalid, 1);
      check("inv_val", val, 0);
      check("inv_blank", blank, 0);
      hold(7'h7F, 10);
      check("blank_blank", blank, 1);
      check("blank_invalid", invalid, 0);
      check("blank_count", change_count, 2);

      // Test 5: narrow counter wrap and clear on the commit cycle
      do_reset();
      for (int i = 0; i < 5; i++) begin
         hold((i % 2 == 0) ? 7'h12 : 7'h19, 8);
         check("w2_count", change_count2, (i + 1) % 4);
      end
      do_reset();
      leds = 7'h02;
      repeat (SC + 1) step();
      clear_count = 1'b1;
      step();
      clear_count = 1'b0;
      check("clear_commit_update", update, 1);
      check("clear_commit_count8", change_count, 1);
      check("clear_commit_count2", change_count2, 1);
      hold(7'h02, 4);

      // Test 6: reset in the middle of filtering
      do_reset();
      leds = 7'h30;
      step();
      step();
      reset = 1'b1;
      step();
      check("midrst_update", update, 0);
      check("midrst_blank", blank, 1);
      check("midrst_count", change_count, 0);
      reset = 1'b0;
      latency(7'h30, "lat_after_reset");
      check("midrst_val", val, 3);

      // 8-bit counter wrap
      do_reset();
      for (int i = 0; i < 260; i++) hold((i % 2 == 0) ? 7'h21 : 7'h46, SC + 3);
      check("wrap_count8", change_count, 260 % 256);

      // Random traffic
      for (int s = 0; s < 300; s++) begin
         int r;
         int n;
         logic [6:0] p;
         r = $urandom_range(0, 9);
         if (r < 6) p = glyph[$urandom_range(0, 15)];
         else if (r == 6) p = 7'h7F;
         else if (r == 7) p = 7'($urandom_range(0, 127));
         else p = leds;
         leds = p;
         n = $urandom_range(1, 8);
         for (int c = 0; c < n; c++) begin
            clear_count = ($urandom_range(0, 11) == 0);
            reset = ($urandom_range(0, 199) == 0);
            step();
         end
         clear_count = 1'b0;
         reset = 1'b0;
      end
      hold(leds, 10);

      check("queue_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
